// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared constants and count-width helper for the LIFO stack
package stack_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 16;

  // Occupancy runs 0..DEPTH inclusive, so it needs one more state than DEPTH.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - DEPTH x WIDTH storage, synchronous write, asynchronous read, no reset
module stack_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_stack.sv
// rtl/param_stack.sv - parameterised LIFO stack with replace-top, sticky error flags and registered pop data
module param_stack
  import stack_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic                          re,
  input  logic                          clr_err,
  input  logic [WIDTH-1:0]              data_in,
  output logic [WIDTH-1:0]              data_out,
  output logic                          rd_valid,
  output logic [WIDTH-1:0]              top,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int CW = count_width(DEPTH);
  localparam int AW = addr_width(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             do_push, do_pop, do_repl;
  logic             mem_we;
  logic [AW-1:0]    top_addr, waddr;
  logic [WIDTH-1:0] top_word;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= CW'(AF_LEVEL));

  // Simultaneous push+pop on an empty stack degrades to a plain push.
  assign do_push = we & ((~re & ~full) | (re & empty));
  assign do_pop  = re & ~we & ~empty;
  assign do_repl = we & re & ~empty;

  assign top_addr = AW'(count_q) - AW'(1);
  assign waddr    = do_repl ? top_addr : AW'(count_q);
  assign mem_we   = (do_push | do_repl) & ~rst;

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en_i (mem_we),
    .waddr_i (waddr),
    .wdata_i (data_in),
    .raddr_i (top_addr),
    .rdata_o (top_word)
  );

  always_comb begin
    count_d     = count_q;
    data_out_d  = data_out_q;
    rd_valid_d  = 1'b0;
    if (do_push) begin
      count_d = count_q + CW'(1);
    end else if (do_pop) begin
      count_d = count_q - CW'(1);
    end
    if (do_pop | do_repl) begin
      data_out_d = top_word;
      rd_valid_d = 1'b1;
    end
    // A new error on the same edge as clr_err wins.
    overflow_d  = (we & ~re & full)  | (overflow_q  & ~clr_err);
    underflow_d = (re & ~we & empty) | (underflow_q & ~clr_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      data_out_q  <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign top       = empty ? '0 : top_word;
  assign count     = count_q;
  assign data_out  = data_out_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (>=2, any integer, not restricted to powers of two).
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-2, count at or above which almost_full asserts (1..DEPTH).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port we  input  1  push request.
REQ-007 SHALL have port re  input  1  pop request.
REQ-008 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 SHALL have port data_in  input  WIDTH  push data.
REQ-010 SHALL have port data_out  output  WIDTH  registered popped word.
REQ-011 SHALL have port rd_valid  output  1  one-cycle pulse; data_out updated by an accepted pop on the preceding edge.
REQ-012 SHALL have port top  output  WIDTH  combinational peek of the top entry; 0 when empty.
REQ-013 SHALL have port count  output  CW=$clog2(DEPTH+1)  current occupancy.
REQ-014 SHALL have ports full, empty, almost_full  output  1 each  occupancy flags.
REQ-015 SHALL have ports overflow, underflow  output  1 each  sticky error flags.

Function
REQ-016 Flags SHALL be combinational from count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL).
REQ-017 Push only (we & !re), not full: mem[count]<=data_in, count+1.
REQ-018 Pop only (re & !we), not empty: data_out<=mem[count-1], count-1, rd_valid=1 next cycle.
REQ-019 Push and pop together, not empty (full included): replace-top; data_out<=old top, mem[count-1]<=data_in, count unchanged, rd_valid=1 next cycle.
REQ-020 Push and pop together, empty: push accepted as in REQ-017, pop ignored, underflow not set, rd_valid=0.
REQ-021 Push only when full: ignored, memory and count unchanged, overflow<=1.
REQ-022 Pop only when empty: ignored, data_out holds, rd_valid=0, underflow<=1.
REQ-023 overflow/underflow SHALL stay set until clr_err=1 or reset; when clr_err coincides with a new error, the flag SHALL be 1 after the edge (set wins).
REQ-024 data_out SHALL hold its value when no pop is accepted.
REQ-025 Latency: push visible on top and count the cycle after the edge; pop data on data_out the cycle after the edge.
REQ-026 count arithmetic SHALL be CW bits, never wrap: saturates at 0 and DEPTH by REQ-021/022.

Reset
REQ-027 rst=1 SHALL immediately force count=0, data_out=0, rd_valid=0, overflow=0, underflow=0, regardless of clk; hence empty=1, full=0, top=0.
REQ-028 Storage array SHALL NOT be reset; contents are don't-care after reset and never observable (top gated by empty).
REQ-029 A push or pop on the edge where rst is high or deasserting SHALL have no effect.

Structure
REQ-030 Package stack_pkg SHALL hold a count-width function (clog2 of DEPTH+1) and default WIDTH/DEPTH constants.
REQ-031 Storage SHALL be sub-module stack_mem: DEPTH x WIDTH, one synchronous write port, one asynchronous read port, no reset.
REQ-032 Control (count, flags, errors, data_out, rd_valid) SHALL reside in param_stack.

Verification (WIDTH=8, DEPTH=4, AF_LEVEL=3)
REQ-033 Push 0x11,0x22,0x33,0x44 -> count 1..4, almost_full at 3, full at 4; top=0x44.
REQ-034 From full, pop x4 -> data_out 0x44,0x33,0x22,0x11 each with rd_valid pulse; empty=1 after; fifth pop -> underflow=1, data_out stays 0x11.
REQ-035 From full, push 0x55 -> overflow=1, top still 0x44; clr_err -> overflow=0.
REQ-036 Stack [0x11,0x22], we=re=1 with 0x99 -> data_out=0x22, top=0x99, count=2; on empty, we=re=1 with 0x77 -> count=1, rd_valid=0, underflow=0.
REQ-037 Assert rst asynchronously mid-sequence between edges -> count=0, data_out=0, flags cleared before next edge; subsequent push 0xAB -> top=0xAB.
